// File: rtl/mips_pkg.sv
// Shared MIPS core types for the multiply/divide sequencer.
// Holds the op and state enums and the mfhi/mflo request encodings.
package mips_pkg;

   typedef enum logic {
      MD_MULT = 1'b0,
      MD_DIV  = 1'b1
   } muldiv_op_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2
   } muldiv_state_t;

   localparam logic [1:0] MFHL_NONE = 2'b00;
   localparam logic [1:0] MFHL_HI   = 2'b10;
   localparam logic [1:0] MFHL_LO   = 2'b01;

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute/Decode <-> mult/div engine bundle.
// master: pipeline side (startE, opE, srcaE, srcbE, mfhlD out; busy, stall, done, hi, lo in)
// slave : engine side (the reverse directions)
interface muldiv_sequencer_if #(
   parameter int WIDTH = 32
);
   logic             startE;
   logic             opE;
   logic [WIDTH-1:0] srcaE;
   logic [WIDTH-1:0] srcbE;
   logic [1:0]       mfhlD;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;

   modport master (
      output startE, opE, srcaE, srcbE, mfhlD,
      input  busy, stall, done, hi, lo
   );

   modport slave (
      input  startE, opE, srcaE, srcbE, mfhlD,
      output busy, stall, done, hi, lo
   );
endinterface

// File: rtl/muldiv_sequencer_step.sv
// One combinational iteration: shift-add (MULT) or restoring step (DIV).
// Ports: op; acc/mcand/mplier in -> next values out. DIV uses acc = {rem, quo}
// and the low WIDTH+1 bits of mcand as the divisor; mcand/mplier pass through.
module muldiv_step
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  muldiv_op_t         op,
   input  logic [2*WIDTH-1:0] acc_in,
   input  logic [2*WIDTH-1:0] mcand_in,
   input  logic [WIDTH-1:0]   mplier_in,
   output logic [2*WIDTH-1:0] acc_out,
   output logic [2*WIDTH-1:0] mcand_out,
   output logic [WIDTH-1:0]   mplier_out
);

   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   divisor;
   logic [WIDTH-1:0] diff;
   logic             fits;

   always_comb begin
      acc_out    = acc_in;
      mcand_out  = mcand_in;
      mplier_out = mplier_in;
      shifted    = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-1]};
      divisor    = mcand_in[WIDTH:0];
      fits       = (shifted >= divisor);
      // the remainder stays below the divisor, so WIDTH bits hold it
      diff       = shifted[WIDTH-1:0] - divisor[WIDTH-1:0];
      if (op == MD_MULT) begin
         if (mplier_in[0])
            acc_out = acc_in + mcand_in;
         mcand_out  = mcand_in << 1;
         mplier_out = mplier_in >> 1;
      end else begin
         acc_out = {(fits ? diff : shifted[WIDTH-1:0]),
                    acc_in[WIDTH-2:0], fits};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative signed MULT/DIV engine owning HI/LO, with pipeline stall request.
// Ports: clk, reset (sync, active-high), bus (slave: startE, opE, srcaE, srcbE,
// mfhlD in; busy, stall, done, hi, lo out).
// Optional macro MULDIV_EARLY_TERM_EN: MULT leaves CALC once the multiplier
// register empties; results are identical either way.
module muldiv_sequencer
   import mips_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input logic              clk,
   input logic              reset,
   muldiv_sequencer_if.slave bus
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   function automatic logic [WIDTH:0] mag(input logic [WIDTH-1:0] x);
      logic [WIDTH:0] s;
      s = {x[WIDTH-1], x};
      return x[WIDTH-1] ? -s : s;
   endfunction

   muldiv_state_t      state;
   muldiv_op_t         op_q;
   logic [CW-1:0]      cnt;
   logic               sa;
   logic               sb;
   logic               divz;
   logic [WIDTH-1:0]   a_raw;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   hi_q;
   logic [WIDTH-1:0]   lo_q;
   logic               done_q;
   logic               busy_q;

   logic [WIDTH:0]     mag_a;
   logic [WIDTH:0]     mag_b;
   logic [2*WIDTH-1:0] acc_nx;
   logic [2*WIDTH-1:0] mcand_nx;
   logic [WIDTH-1:0]   mplier_nx;
   logic               last;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   assign mag_a = mag(bus.srcaE);
   assign mag_b = mag(bus.srcbE);

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .op         (op_q),
      .acc_in     (acc),
      .mcand_in   (mcand),
      .mplier_in  (mplier),
      .acc_out    (acc_nx),
      .mcand_out  (mcand_nx),
      .mplier_out (mplier_nx)
   );

`ifdef MULDIV_EARLY_TERM_EN
   assign last = (cnt == CNT_LAST) ||
                 (op_q == MD_MULT && mplier_nx == '0);
`else
   assign last = (cnt == CNT_LAST);
`endif

   // sign correction of the magnitude result
   always_comb begin
      prod   = (sa ^ sb) ? -acc : acc;
      quo    = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem    = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      res_hi = prod[2*WIDTH-1:WIDTH];
      res_lo = prod[WIDTH-1:0];
      if (op_q == MD_DIV) begin
         res_hi = divz ? a_raw : rem;
         res_lo = divz ? '1 : quo;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= MD_IDLE;
         op_q   <= MD_MULT;
         cnt    <= '0;
         sa     <= 1'b0;
         sb     <= 1'b0;
         divz   <= 1'b0;
         a_raw  <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         done_q <= 1'b0;
         busy_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state)
            MD_IDLE: begin
               if (bus.startE) begin
                  op_q   <= muldiv_op_t'(bus.opE);
                  sa     <= bus.srcaE[WIDTH-1];
                  sb     <= bus.srcbE[WIDTH-1];
                  divz   <= (bus.srcbE == '0);
                  a_raw  <= bus.srcaE;
                  cnt    <= '0;
                  mplier <= mag_b[WIDTH-1:0];
                  if (muldiv_op_t'(bus.opE) == MD_MULT) begin
                     acc   <= '0;
                     mcand <= {{(WIDTH-1){1'b0}}, mag_a};
                  end else begin
                     acc   <= {{WIDTH{1'b0}}, mag_a[WIDTH-1:0]};
                     mcand <= {{(WIDTH-1){1'b0}}, mag_b};
                  end
                  busy_q <= 1'b1;
                  state  <= MD_CALC;
               end
            end
            MD_CALC: begin
               acc    <= acc_nx;
               mcand  <= mcand_nx;
               mplier <= mplier_nx;
               cnt    <= cnt + 1'b1;
               if (last)
                  state <= MD_FIX;
            end
            MD_FIX: begin
               hi_q   <= res_hi;
               lo_q   <= res_lo;
               done_q <= 1'b1;
               busy_q <= 1'b0;
               state  <= MD_IDLE;
            end
            default: begin
               busy_q <= 1'b0;
               state  <= MD_IDLE;
            end
         endcase
      end
   end

   // combinational so Decode/Execute hold in the same cycle
   assign bus.stall = busy_q &
                      (bus.startE | (bus.mfhlD != MFHL_NONE));
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.hi    = hi_q;
   assign bus.lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer (latency, results, stall, reset).
// Honours MULDIV_EARLY_TERM_EN for the expected MULT latency.
module tb_muldiv_sequencer;
   import mips_pkg::*;

   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_sequencer_if #(.WIDTH(W)) bus ();

   muldiv_sequencer #(.WIDTH(W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // done cycle relative to the start cycle
   function automatic int exp_lat(input logic op, input logic [31:0] b);
`ifdef MULDIV_EARLY_TERM_EN
      logic [31:0] m;
      int n;
      if (op) return 34;
      m = b[31] ? -b : b;
      n = 1;
      for (int i = 0; i < 32; i++)
         if (m[i]) n = i + 1;
      return n + 2;
`else
      return 34;
`endif
   endfunction

   task automatic run_op(input string tag, input logic op,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] ehi, input logic [31:0] elo);
      int lat;
      int bc;
      bus.startE = 1'b1;
      bus.opE    = op;
      bus.srcaE  = a;
      bus.srcbE  = b;
      lat = 0;
      bc  = 0;
      do begin
         step();
         lat++;
         if (lat == 1) bus.startE = 1'b0;
         if (bus.busy) bc++;
      end while (!bus.done && lat < 100);
      check({tag, "_lat"}, lat, exp_lat(op, b));
      check({tag, "_busy"}, bc, lat - 1);
      check({tag, "_hi"}, bus.hi, ehi);
      check({tag, "_lo"}, bus.lo, elo);
   endtask

   int st_cnt;
   int d2;

   initial begin
      reset      = 1'b1;
      bus.startE = 1'b0;
      bus.opE    = 1'b0;
      bus.srcaE  = '0;
      bus.srcbE  = '0;
      bus.mfhlD  = MFHL_NONE;
      repeat (2) step();
      reset = 1'b0;
      step();
      check("rst_busy", bus.busy, 0);
      check("rst_stall", bus.stall, 0);
      check("rst_done", bus.done, 0);
      check("rst_hi", bus.hi, 0);
      check("rst_lo", bus.lo, 0);

      run_op("mul_7_m3", 0, 32'd7, -32'sd3, 32'hFFFFFFFF, 32'hFFFFFFEB);
      step();
      check("done_pulse", bus.done, 0);
      run_op("div_m7_2", 1, -32'sd7, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
      run_op("div_7_m2", 1, 32'd7, -32'sd2, 32'd1, 32'hFFFFFFFD);
      run_op("div_5_0", 1, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF);
      run_op("div_m8_0", 1, -32'sd8, 32'd0, 32'hFFFFFFF8, 32'hFFFFFFFF);
      run_op("div_min_m1", 1, 32'h80000000, 32'hFFFFFFFF,
             32'd0, 32'h80000000);
      run_op("mul_min_min", 0, 32'h80000000, 32'h80000000,
             32'h40000000, 32'd0);
      run_op("mul_m1_5", 0, 32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB);
      run_op("mul_x_0", 0, 32'h12345678, 32'd0, 32'd0, 32'd0);
      run_op("div_100_7", 1, 32'd100, 32'd7, 32'd2, 32'd14);

      // mfhi held from T+5 while a DIV runs
      bus.startE = 1'b1;
      bus.opE    = 1'b1;
      bus.srcaE  = 32'd200;
      bus.srcbE  = 32'd7;
      st_cnt = 0;
      for (int k = 1; k <= 34; k++) begin
         step();
         if (k == 1) bus.startE = 1'b0;
         if (k == 2) check("mf_pre_stall", bus.stall, 0);
         if (k == 5) begin
            bus.mfhlD = MFHL_HI;
            #1;
         end
         if (k >= 5 && k <= 33 && bus.stall) st_cnt++;
         if (k == 34) begin
            check("mf_stall_end", bus.stall, 0);
            check("mf_done", bus.done, 1);
            check("mf_hi_new", bus.hi, 32'd4);
            check("mf_lo_new", bus.lo, 32'd28);
         end
      end
      check("mf_stall_cnt", st_cnt, 29);
      bus.mfhlD = MFHL_NONE;

      // second op held from T+3 while busy
      bus.startE = 1'b1;
      bus.opE    = 1'b1;
      bus.srcaE  = 32'd100;
      bus.srcbE  = 32'd7;
      d2 = 0;
      for (int k = 1; k <= 80 && d2 == 0; k++) begin
         step();
         if (k == 1) bus.startE = 1'b0;
         if (k == 3) begin
            bus.startE = 1'b1;
            bus.srcaE  = -32'sd100;
            bus.srcbE  = 32'd7;
            #1;
            check("b2b_stall", bus.stall, 1);
         end
         if (k == 34) begin
            check("b2b_done1", bus.done, 1);
            check("b2b_lo1", bus.lo, 32'd14);
            check("b2b_idle_stall", bus.stall, 0);
         end
         if (k == 35) begin
            bus.startE = 1'b0;
            check("b2b_busy2", bus.busy, 1);
         end
         if (k > 34 && bus.done) d2 = k;
      end
      check("b2b_done2_at", d2, 68);
      check("b2b_hi2", bus.hi, 32'hFFFFFFFE);
      check("b2b_lo2", bus.lo, 32'hFFFFFFF2);

      // reset mid-operation
      bus.startE = 1'b1;
      bus.opE    = 1'b1;
      bus.srcaE  = 32'd100;
      bus.srcbE  = 32'd7;
      for (int k = 1; k <= 11; k++) begin
         step();
         if (k == 1) bus.startE = 1'b0;
         if (k == 10) reset = 1'b1;
      end
      check("mid_rst_busy", bus.busy, 0);
      check("mid_rst_hi", bus.hi, 0);
      check("mid_rst_lo", bus.lo, 0);
      reset = 1'b0;
      run_op("mul_2_3", 0, 32'd2, 32'd3, 32'd0, 32'd6);
      run_op("mul_3_1", 0, 32'd3, 32'd1, 32'd0, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
